video_timing_gen: RTL and testbench



---
 rtl/video_timing_gen.sv | 121 ++++++++++++
 tb/tb_video_timing_gen.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator: registered de/sync/coordinate outputs
// plus an early data-enable that leads de by LEAD pixel clocks.
module video_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int LEAD     = 2
) (
  input  logic        clk_pixel,
  input  logic        resetn,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        line_start,
  output logic        frame_start,
  output logic        de_early
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Lead counters start LEAD pixels ahead so de_early(t) == de(t+LEAD).
  localparam logic [10:0] HE_RST = 11'(LEAD % H_TOTAL);
  localparam logic [9:0]  VE_RST = 10'((LEAD / H_TOTAL) % V_TOTAL);

  logic [10:0] h_q, h_d, he_q, he_d;
  logic [9:0]  v_q, v_d, ve_q, ve_d;

  logic        de_q, de_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        ls_q, ls_d;
  logic        fs_q, fs_d;
  logic        dee_q, dee_d;

  logic        active;

  always_comb begin
    h_d  = (h_q == H_LAST) ? '0 : h_q + 11'd1;
    v_d  = v_q;
    if (h_q == H_LAST) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end

    he_d = (he_q == H_LAST) ? '0 : he_q + 11'd1;
    ve_d = ve_q;
    if (he_q == H_LAST) begin
      ve_d = (ve_q == V_LAST) ? '0 : ve_q + 10'd1;
    end

    active  = (h_q < H_ACT) && (v_q < V_ACT);
    de_d    = active;
    hsync_d = ((h_q >= HS_BEG) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
    vsync_d = ((v_q >= VS_BEG) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
    x_d     = active ? h_q : '0;
    y_d     = active ? v_q : '0;
    ls_d    = (h_q == '0);
    fs_d    = (h_q == '0) && (v_q == '0);
    dee_d   = (he_q < H_ACT) && (ve_q < V_ACT);
  end

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      h_q     <= '0;
      v_q     <= '0;
      he_q    <= HE_RST;
      ve_q    <= VE_RST;
      de_q    <= 1'b0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      x_q     <= '0;
      y_q     <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      dee_q   <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      he_q    <= he_d;
      ve_q    <= ve_d;
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      dee_q   <= dee_d;
    end
  end

  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign de_early    = dee_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 1024x768 raster plus two tiny rasters checked
// cycle-by-cycle against a closed-form position model.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        de_a, hs_a, vs_a, ls_a, fs_a, dee_a;
  logic [10:0] x_a;
  logic [9:0]  y_a;
  logic        de_b, hs_b, vs_b, ls_b, fs_b, dee_b;
  logic [10:0] x_b;
  logic [9:0]  y_b;
  logic        de_c, hs_c, vs_c, ls_c, fs_c, dee_c;
  logic [10:0] x_c;
  logic [9:0]  y_c;

  video_timing_gen u_def (
    .clk_pixel(clk), .resetn(resetn), .de(de_a), .hsync(hs_a), .vsync(vs_a),
    .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a), .de_early(dee_a)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .LEAD(3)
  ) u_sm (
    .clk_pixel(clk), .resetn(resetn), .de(de_b), .hsync(hs_b), .vsync(vs_b),
    .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b), .de_early(dee_b)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .LEAD(0)
  ) u_l0 (
    .clk_pixel(clk), .resetn(resetn), .de(de_c), .hsync(hs_c), .vsync(vs_c),
    .x(x_c), .y(y_c), .line_start(ls_c), .frame_start(fs_c), .de_early(dee_c)
  );

  logic [26:0] obs_a, obs_b, obs_c;
  assign obs_a = {fs_a, ls_a, dee_a, vs_a, hs_a, de_a, y_a, x_a};
  assign obs_b = {fs_b, ls_b, dee_b, vs_b, hs_b, de_b, y_b, x_b};
  assign obs_c = {fs_c, ls_c, dee_c, vs_c, hs_c, de_c, y_c, x_c};

  int checks = 0;
  int errors = 0;
  int p;
  int de_hi = 0, de_lo = 0, hs_lo = 0, hs_first = -1, de_fall = -1;
  int last_fs;
  logic prev_vs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (pos %0d)", tag, obs, exp, p);
    end
  endtask

  // Expected outputs for raster position p (clocks since (0,0)).
  function automatic logic [26:0] model(input int pos, input int ha, input int hf,
                                        input int hsw, input int hb, input int va,
                                        input int vf, input int vsw, input int vb,
                                        input bit hp, input bit vp, input int lead);
    int ht, vt, h, v, he, ve;
    bit act, acte, hsa, vsa;
    logic [10:0] xx;
    logic [9:0]  yy;
    ht   = ha + hf + hsw + hb;
    vt   = va + vf + vsw + vb;
    h    = pos % ht;
    v    = (pos / ht) % vt;
    he   = (pos + lead) % ht;
    ve   = ((pos + lead) / ht) % vt;
    act  = (h < ha) && (v < va);
    acte = (he < ha) && (ve < va);
    hsa  = (h >= ha + hf) && (h < ha + hf + hsw);
    vsa  = (v >= va + vf) && (v < va + vf + vsw);
    xx   = act ? 11'(h) : 11'd0;
    yy   = act ? 10'(v) : 10'd0;
    return {(h == 0 && v == 0), (h == 0), acte, vsa ? vp : ~vp, hsa ? hp : ~hp,
            act, yy, xx};
  endfunction

  task automatic run(input int n, input bit stats);
    p = 0;
    last_fs = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("def", {5'd0, obs_a}, {5'd0, model(p, 1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0, 2)});
      check("sm",  {5'd0, obs_b}, {5'd0, model(p, 8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0, 3)});
      check("l0",  {5'd0, obs_c}, {5'd0, model(p, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 0)});
      if (stats && p < 1344) begin
        if (de_a) de_hi++; else de_lo++;
        if (!de_a && de_fall < 0) de_fall = p;
        if (!hs_a) begin
          hs_lo++;
          if (hs_first < 0) hs_first = p;
        end
      end
      if (fs_b) begin
        if (last_fs >= 0) check("fs_period", p - last_fs, 98);
        last_fs = p;
      end
      if (p > 0 && vs_b !== prev_vs) check("vs_on_ls", {31'd0, ls_b}, 32'd1);
      prev_vs = vs_b;
      p++;
    end
  endtask

  initial begin
    p = -1;
    resetn = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_def", {5'd0, obs_a}, {5'd0, 3'b000, 1'b1, 1'b1, 1'b0, 10'd0, 11'd0});
    check("rst_sm",  {5'd0, obs_b}, {5'd0, 3'b000, 1'b1, 1'b1, 1'b0, 10'd0, 11'd0});
    check("rst_l0",  {5'd0, obs_c}, 32'd0);

    resetn = 1'b1;
    run(3189, 1'b1);
    check("de_hi", de_hi, 1024);
    check("de_lo", de_lo, 320);
    check("hs_lo", hs_lo, 136);
    check("hs_delay", hs_first - de_fall, 24);
    check("mid_x", {21'd0, x_a}, 32'd500);
    check("mid_y", {22'd0, y_a}, 32'd2);

    // Asynchronous assert between edges: outputs must drop with no clock.
    #2;
    resetn = 1'b0;
    #1;
    check("arst_def", {5'd0, obs_a}, {5'd0, 3'b000, 1'b1, 1'b1, 1'b0, 10'd0, 11'd0});
    check("arst_sm",  {5'd0, obs_b}, {5'd0, 3'b000, 1'b1, 1'b1, 1'b0, 10'd0, 11'd0});
    check("arst_l0",  {5'd0, obs_c}, 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rel_fs", {31'd0, fs_a}, 32'd1);
    check("rel_ls", {31'd0, ls_a}, 32'd1);
    check("rel_de", {31'd0, de_a}, 32'd1);
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    run(300, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
